// File: rtl/neuron_mac.sv
// neuron_mac: 4-stage MAC for one fully-connected neuron, driving its weight-memory read port.
// Define NEURON_SAT_EN for saturating accumulate and bias adds; otherwise both wrap.
module neuron_mac #(
  parameter int numWeight = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [dataWidth-1:0]     in_data,
  input  logic                     in_valid,
  input  logic [2*dataWidth-1:0]   bias,
  output logic                     ren,
  output logic [addressWidth-1:0]  radd,
  input  logic [dataWidth-1:0]     wout,
  output logic [2*dataWidth-1:0]   sum,
  output logic                     sum_valid,
  output logic                     busy
);
  localparam int SW = 2*dataWidth;
  localparam logic [addressWidth-1:0] LAST = addressWidth'(numWeight-1);
  logic [addressWidth-1:0] cnt;
  logic v1, f1, l1, v2, f2, l2, v3, l3;
  logic signed [dataWidth-1:0] in_d;
  logic signed [SW-1:0] mul, acc;
  function automatic logic signed [SW-1:0] add(input logic signed [SW-1:0] a, input logic signed [SW-1:0] b);
`ifdef NEURON_SAT_EN
    logic signed [SW:0] s;
    s = {a[SW-1], a} + {b[SW-1], b};
    return s[SW] != s[SW-1] ? {s[SW], {(SW-1){~s[SW]}}} : s[SW-1:0];
`else
    return a + b;
`endif
  endfunction
  assign ren = in_valid;
  assign radd = cnt;
  assign busy = (cnt != '0) | v1 | v2 | v3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      {v1, f1, l1, v2, f2, l2, v3, l3} <= '0;
      in_d <= '0;
      mul <= '0;
      acc <= '0;
      sum <= '0;
      sum_valid <= 1'b0;
    end else begin
      if (in_valid) cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      v1 <= in_valid;
      f1 <= cnt == '0;
      l1 <= cnt == LAST;
      if (in_valid) in_d <= $signed(in_data);
      v2 <= v1;
      f2 <= f1;
      l2 <= l1;
      if (v1) mul <= in_d * $signed(wout);
      v3 <= v2;
      l3 <= v2 & l2;
      if (v2) acc <= f2 ? mul : add(acc, mul);
      sum_valid <= v3 & l3;
      if (v3 & l3) sum <= add(acc, $signed(bias));
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed and random stimulus on a 3-input and a 1-input neuron,
// checked cycle by cycle against a dot-product reference model.
module tb_neuron_mac;
  logic clk = 0, rst = 0, in_valid = 0;
  logic [15:0] in_data = 0, wout3, wout1;
  logic [31:0] bias = 0, sum3, sum1;
  logic ren3, ren1, sv3, sv1, busy3, busy1;
  logic [1:0] radd3;
  logic radd1;
  logic signed [15:0] mem3 [0:3];
  logic signed [15:0] mem1 [0:1];
  int cyc = 0, npass = 0, ntot = 0;
  typedef struct {int due; longint dot;} res_t;
  res_t q3[$], q1[$];
  int idx = 0, last_beat = -100;
  longint acc_m = 0, p;
  logic [31:0] hold3 = 0, hold1 = 0;
  logic e3, e1, act;

  neuron_mac #(.numWeight(3), .addressWidth(2), .dataWidth(16)) d3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .bias(bias),
    .ren(ren3), .radd(radd3), .wout(wout3), .sum(sum3), .sum_valid(sv3), .busy(busy3));
  neuron_mac #(.numWeight(1), .addressWidth(1), .dataWidth(16)) d1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .bias(bias),
    .ren(ren1), .radd(radd1), .wout(wout1), .sum(sum1), .sum_valid(sv1), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ren3) wout3 <= mem3[radd3];
  always @(posedge clk) if (ren1) wout1 <= mem1[radd1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic longint fold(input longint a);
`ifdef NEURON_SAT_EN
    return a > 64'sd2147483647 ? 64'sd2147483647 : a < -64'sd2147483648 ? -64'sd2147483648 : a;
`else
    int t;
    t = int'(a[31:0]);
    return longint'(t);
`endif
  endfunction

  // reference: each result is the clamped/wrapped running dot product plus bias, due 4 cycles after its last beat
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_sum_valid", sv3, 0);
      chk("rst_sum", sum3, 0);
      chk("rst_busy", busy3, 0);
      chk("rst_radd", radd3, 0);
      idx = 0; acc_m = 0; last_beat = -100; hold3 = 0; hold1 = 0;
      q3.delete(); q1.delete();
    end else begin
      act = cyc - last_beat >= 1 && cyc - last_beat <= 3;
      chk("busy3", busy3, idx != 0 || act);
      chk("busy1", busy1, act);
      chk("ren3", ren3, in_valid);
      if (in_valid) begin
        chk("radd3", radd3, idx);
        chk("radd1", radd1, 0);
        p = longint'($signed(in_data)) * longint'(mem3[idx]);
        acc_m = idx == 0 ? p : fold(acc_m + p);
        if (idx == 2) q3.push_back('{cyc + 4, acc_m});
        q1.push_back('{cyc + 4, longint'($signed(in_data)) * longint'(mem1[0])});
        idx = idx == 2 ? 0 : idx + 1;
        last_beat = cyc;
      end
      e3 = q3.size() != 0 && q3[0].due == cyc;
      e1 = q1.size() != 0 && q1[0].due == cyc;
      chk("sum_valid3", sv3, e3);
      chk("sum_valid1", sv1, e1);
      if (e3) begin hold3 = 32'(fold(q3[0].dot + longint'($signed(bias)))); void'(q3.pop_front()); end
      if (e1) begin hold1 = 32'(fold(q1[0].dot + longint'($signed(bias)))); void'(q1.pop_front()); end
      chk("sum3", sum3, hold3);
      chk("sum1", sum1, hold1);
    end
  end

  task automatic drive(input logic v, input logic [15:0] d);
    @(posedge clk); #1 in_valid = v; in_data = d;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 16'($urandom));
  endtask
  task automatic setup(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [15:0] w1, input logic [31:0] bb);
    @(posedge clk); #1 mem3[0] = a; mem3[1] = b; mem3[2] = c; mem1[0] = w1; bias = bb;
  endtask

  initial begin
    foreach (mem3[i]) mem3[i] = 0;
    foreach (mem1[i]) mem1[i] = 0;
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    setup(1, 2, 3, -2, 10);
    drive(1, 4); drive(1, 5); drive(1, 6); idle(8);
    chk("basic", sum3, 42);
    setup(1, 2, 3, -2, 0);
    drive(1, 4); drive(1, 5); drive(1, 6);
    drive(1, 16'hFFFF); drive(1, 16'hFFFF); drive(1, 16'hFFFF); idle(8);
    chk("back2back", sum3, 32'hFFFF_FFFA);
    setup(1, 2, 3, -2, 10);
    drive(1, 4); idle(2); drive(1, 5); idle(2); drive(1, 6); idle(8);
    chk("gapped", sum3, 42);
    setup(16'h7FFF, 16'h7FFF, 16'h7FFF, -2, 0);
    drive(1, 16'h7FFF); drive(1, 16'h7FFF); drive(1, 16'h7FFF); idle(8);
`ifdef NEURON_SAT_EN
    chk("overflow", sum3, 32'h7FFF_FFFF);
`else
    chk("overflow", sum3, 32'hBFFD_0003);
`endif
    setup(1, 2, 3, -2, 10);
    drive(1, 4); drive(1, 5);
    @(posedge clk); #1 in_valid = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    drive(1, 4); drive(1, 5); drive(1, 6); idle(8);
    chk("rst_mid", sum3, 42);
    setup(1, 2, 3, 16'hFFFE, -4);
    drive(1, 3); idle(6);
    chk("neg1", sum1, 32'hFFFF_FFF6);
    for (int r = 0; r < 8; r++) begin
      setup(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $urandom);
      repeat ($urandom_range(12, 40)) begin
        logic [15:0] d;
        d = $urandom_range(0, 5) == 0 ? 16'h8000 : $urandom_range(0, 5) == 0 ? 16'h7FFF : 16'($urandom);
        drive($urandom_range(0, 3) != 0, d);
      end
      idle(8);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
